// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: merges a one-entry download write buffer and a
// one-entry cartridge read buffer onto a single request/ack memory port,
// with a watchdog that aborts accesses whose mem_ack never arrives.
// Optional feature: define CART_READ_CACHE_EN to add a one-entry read tag so
// a repeated read of the last completed address is answered without memory.
module cart_mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cart_rd,
  input  logic [19:0] cart_a,
  output logic [7:0]  cart_d,
  output logic        cart_valid,
  output logic [5:0]  cart_pages,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout,
  output logic        ovf_err,
  output logic        tmo_err
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t      state_q, state_d;
  logic        wbuf_full_q, wbuf_full_d;
  logic [24:0] wbuf_addr_q, wbuf_addr_d;
  logic [7:0]  wbuf_data_q, wbuf_data_d;
  logic        rd_pend_q, rd_pend_d;
  logic [19:0] rd_addr_q, rd_addr_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_din_q, mem_din_d;
  logic [7:0]  cart_d_q, cart_d_d;
  logic        cart_valid_q, cart_valid_d;
  logic [5:0]  cart_pages_q, cart_pages_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic        dl_q, dl_d;
`ifdef CART_READ_CACHE_EN
  logic        tag_vld_q, tag_vld_d;
  logic [19:0] tag_addr_q, tag_addr_d;
`endif

  logic rd_in, hit, wr_ack, rd_ack, expired, wr_acc, free;

  assign rd_in   = cart_rd & ~ioctl_download;
`ifdef CART_READ_CACHE_EN
  assign hit     = rd_in & tag_vld_q & (tag_addr_q == cart_a) & (state_q == IDLE) & ~rd_pend_q;
`else
  assign hit     = 1'b0;
`endif
  assign wr_ack  = (state_q == WR_WAIT) & mem_ack;
  assign rd_ack  = (state_q == RD_WAIT) & mem_ack;
  assign expired = (state_q != IDLE) & ~mem_ack & (wdog_q == TIMEOUT - 8'd1);
  // a write arriving in the cycle the buffer drains takes the freed slot
  assign wr_acc  = ioctl_wr & (~wbuf_full_q | wr_ack);
  // the port is free when idle or when the outstanding access ends this cycle
  assign free    = (state_q == IDLE) | wr_ack | rd_ack | expired;

  // Next-state: buffers, completion handling, then arbitration of the port
  always_comb begin
    state_d      = state_q;
    wbuf_full_d  = wbuf_full_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    rd_pend_d    = rd_pend_q;
    rd_addr_d    = rd_addr_q;
    wdog_d       = wdog_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    cart_d_d     = cart_d_q;
    cart_valid_d = 1'b0;
    cart_pages_d = cart_pages_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    dl_d         = ioctl_download;
`ifdef CART_READ_CACHE_EN
    tag_vld_d    = tag_vld_q;
    tag_addr_d   = tag_addr_q;
`endif

    if (ioctl_download & ~dl_q) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (ioctl_wr & ~wr_acc) ovf_d = 1'b1;

    if (rd_in & ~hit) begin
      rd_pend_d = 1'b1;
      rd_addr_d = cart_a;
    end
    if (ioctl_download) rd_pend_d = 1'b0;
    if (hit) cart_valid_d = 1'b1;

    unique case (state_q)
      IDLE: ;
      WR_WAIT: begin
        wdog_d = wdog_q + 8'd1;
        if (mem_ack) begin
          wbuf_full_d  = 1'b0;
          cart_pages_d = wbuf_addr_q[19:14];
          state_d      = IDLE;
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        wdog_d = wdog_q + 8'd1;
        if (mem_ack) begin
          cart_d_d     = mem_dout;
          cart_valid_d = 1'b1;
          state_d      = IDLE;
`ifdef CART_READ_CACHE_EN
          tag_vld_d    = 1'b1;
          tag_addr_d   = mem_addr_q[19:0];
`endif
        end else if (expired) begin
          cart_d_d     = 8'hFF;
          cart_valid_d = 1'b1;
          tmo_d        = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_acc) begin
      wbuf_full_d = 1'b1;
      wbuf_addr_d = ioctl_addr;
      wbuf_data_d = ioctl_dout;
    end

    // Arbitration sees the post-update buffers, so the IDLE decision is taken
    // in the same cycle an access completes and back-to-back requests chain.
    if (free && wbuf_full_d) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = wbuf_addr_d;
      mem_din_d  = wbuf_data_d;
      wdog_d     = '0;
      state_d    = WR_WAIT;
    end else if (free && rd_pend_d) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = {5'b0, rd_addr_d};
      rd_pend_d  = 1'b0;
      wdog_d     = '0;
      state_d    = RD_WAIT;
    end

`ifdef CART_READ_CACHE_EN
    if (wr_acc || ioctl_download) tag_vld_d = 1'b0;
`endif
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wbuf_full_q  <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      wdog_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      cart_d_q     <= 8'hFF;
      cart_valid_q <= 1'b0;
      cart_pages_q <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      dl_q         <= 1'b0;
`ifdef CART_READ_CACHE_EN
      tag_vld_q    <= 1'b0;
      tag_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wbuf_full_q  <= wbuf_full_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
      wdog_q       <= wdog_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      cart_d_q     <= cart_d_d;
      cart_valid_q <= cart_valid_d;
      cart_pages_q <= cart_pages_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      dl_q         <= dl_d;
`ifdef CART_READ_CACHE_EN
      tag_vld_q    <= tag_vld_d;
      tag_addr_q   <= tag_addr_d;
`endif
    end
  end

  assign ioctl_wait = wbuf_full_q;
  assign cart_d     = cart_d_q;
  assign cart_valid = cart_valid_q;
  assign cart_pages = cart_pages_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign ovf_err    = ovf_q;
  assign tmo_err    = tmo_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: u_dut uses the default TIMEOUT,
// u_tmo uses TIMEOUT=8 for the watchdog scenario. Both share all inputs.
module tb_cart_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr, cart_rd, mem_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, mem_dout;
  logic [19:0] cart_a;

  logic        ioctl_wait, cart_valid, mem_req, mem_we, ovf_err, tmo_err;
  logic [7:0]  cart_d, mem_din;
  logic [5:0]  cart_pages;
  logic [24:0] mem_addr;

  logic        t_ioctl_wait, t_cart_valid, t_mem_req, t_mem_we, t_ovf_err, t_tmo_err;
  logic [7:0]  t_cart_d, t_mem_din;
  logic [5:0]  t_cart_pages;
  logic [24:0] t_mem_addr;

  int vectors = 0;
  int miscompares = 0;
  int wait_cnt, req_cnt, val_cnt;
  logic [7:0] d1, d2;

  always #5 clk_sys = ~clk_sys;

  cart_mem_arbiter u_dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .cart_rd(cart_rd), .cart_a(cart_a),
    .cart_d(cart_d), .cart_valid(cart_valid), .cart_pages(cart_pages),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .ovf_err(ovf_err), .tmo_err(tmo_err)
  );

  cart_mem_arbiter #(.TIMEOUT(8'd8)) u_tmo (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(t_ioctl_wait), .cart_rd(cart_rd), .cart_a(cart_a),
    .cart_d(t_cart_d), .cart_valid(t_cart_valid), .cart_pages(t_cart_pages),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_din(t_mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .ovf_err(t_ovf_err), .tmo_err(t_tmo_err)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // memory model that acks any request in the cycle after it appears
  task automatic run_acked(input int n);
    repeat (n) begin
      mem_ack = mem_req;
      tick(1);
      cart_rd = 1'b0;
      mem_ack = 1'b0;
      req_cnt += int'(mem_req);
      if (cart_valid) begin
        val_cnt++;
        if (val_cnt == 1) d1 = cart_d;
        else d2 = cart_d;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; cart_rd = 1'b0; mem_ack = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cart_a = '0; mem_dout = '0;
    tick(2);
    chk("rst_mem_req",    32'(mem_req),    32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_mem_din",    32'(mem_din),    32'd0);
    chk("rst_cart_d",     32'(cart_d),     32'hFF);
    chk("rst_cart_valid", 32'(cart_valid), 32'd0);
    chk("rst_cart_pages", 32'(cart_pages), 32'd0);
    chk("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_ovf",        32'(ovf_err),    32'd0);
    chk("rst_tmo",        32'(tmo_err),    32'd0);
    reset = 1'b0;
    tick(1);

    // single download write, ack three cycles after the write strobe
    ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h0004000; ioctl_dout = 8'h5A;
    tick(1);
    ioctl_wr = 1'b0;
    chk("w1_req",  32'(mem_req),    32'd1);
    chk("w1_we",   32'(mem_we),     32'd1);
    chk("w1_addr", 32'(mem_addr),   32'h4000);
    chk("w1_din",  32'(mem_din),    32'h5A);
    chk("w1_wait", 32'(ioctl_wait), 32'd1);
    tick(1);
    chk("w1_req_pulse", 32'(mem_req), 32'd0);
    tick(1);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("w1_pages",      32'(cart_pages), 32'd1);
    chk("w1_wait_clear", 32'(ioctl_wait), 32'd0);
    ioctl_download = 1'b0;

    // back-to-back writes, ack arrives ten cycles after the request
    ioctl_addr = 25'h0008000; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    tick(1);
    chk("w2_req",  32'(mem_req),  32'd1);
    chk("w2_addr", 32'(mem_addr), 32'h8000);
    wait_cnt = int'(ioctl_wait);
    req_cnt = 0;
    ioctl_addr = 25'h000C000; ioctl_dout = 8'h22;
    for (int c = 1; c <= 14; c++) begin
      mem_ack = (c == 11);
      tick(1);
      ioctl_wr = 1'b0;
      mem_ack = 1'b0;
      wait_cnt += int'(ioctl_wait);
      req_cnt += int'(mem_req);
    end
    chk("w2_wait_cycles", 32'(wait_cnt), 32'd11);
    chk("w2_no_reissue",  32'(req_cnt),  32'd0);
    chk("w2_ovf",         32'(ovf_err),  32'd1);
    chk("w2_pages",       32'(cart_pages), 32'd2);
    chk("w2_din_kept",    32'(mem_din),  32'h11);

    // download edge clears ovf; reads during download are discarded
    ioctl_download = 1'b1; cart_rd = 1'b1; cart_a = 20'h00555;
    tick(1);
    cart_rd = 1'b0;
    chk("dl_ovf_clr", 32'(ovf_err), 32'd0);
    chk("dl_no_req",  32'(mem_req), 32'd0);
    tick(2);
    ioctl_download = 1'b0;
    tick(1);
    chk("dl_discard_req",  32'(mem_req),  32'd0);
    chk("dl_discard_addr", 32'(mem_addr), 32'h8000);

    // write and read strobed together: write first, read chained on write ack
    ioctl_wr = 1'b1; ioctl_addr = 25'h0010000; ioctl_dout = 8'h33;
    cart_rd = 1'b1; cart_a = 20'h00ABC;
    tick(1);
    ioctl_wr = 1'b0; cart_rd = 1'b0;
    chk("wr_first_req",  32'(mem_req),  32'd1);
    chk("wr_first_we",   32'(mem_we),   32'd1);
    chk("wr_first_addr", 32'(mem_addr), 32'h10000);
    tick(1);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("rd_after_req",   32'(mem_req),    32'd1);
    chk("rd_after_we",    32'(mem_we),     32'd0);
    chk("rd_after_addr",  32'(mem_addr),   32'hABC);
    chk("rd_after_pages", 32'(cart_pages), 32'd4);
    tick(1);
    chk("rd_after_novalid", 32'(cart_valid), 32'd0);
    mem_dout = 8'hC3; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("rd_after_valid", 32'(cart_valid), 32'd1);
    chk("rd_after_data",  32'(cart_d),     32'hC3);
    tick(1);
    chk("rd_valid_pulse", 32'(cart_valid), 32'd0);
    chk("rd_data_hold",   32'(cart_d),     32'hC3);

    // stray ack while idle
    mem_dout = 8'h77; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("idle_ack_valid", 32'(cart_valid), 32'd0);
    chk("idle_ack_data",  32'(cart_d),     32'hC3);

    // read latency from an idle block
    cart_a = 20'h00200; cart_rd = 1'b1;
    tick(1);
    cart_rd = 1'b0;
    chk("lat_req",  32'(mem_req),  32'd1);
    chk("lat_we",   32'(mem_we),   32'd0);
    chk("lat_addr", 32'(mem_addr), 32'h200);
    mem_dout = 8'h5C; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("lat_valid", 32'(cart_valid), 32'd1);
    chk("lat_data",  32'(cart_d),     32'h5C);

    // watchdog on the TIMEOUT=8 instance
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    cart_a = 20'h00300; cart_rd = 1'b1;
    tick(1);
    cart_rd = 1'b0;
    mem_dout = 8'h42; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("tmo_pre_valid", 32'(t_cart_valid), 32'd1);
    chk("tmo_pre_data",  32'(t_cart_d),     32'h42);
    cart_a = 20'h01234; cart_rd = 1'b1;
    tick(1);
    cart_rd = 1'b0;
    chk("tmo_req",  32'(t_mem_req),  32'd1);
    chk("tmo_addr", 32'(t_mem_addr), 32'h1234);
    tick(7);
    chk("tmo_not_yet",       32'(t_tmo_err),    32'd0);
    chk("tmo_not_yet_valid", 32'(t_cart_valid), 32'd0);
    tick(1);
    chk("tmo_err",   32'(t_tmo_err),    32'd1);
    chk("tmo_valid", 32'(t_cart_valid), 32'd1);
    chk("tmo_data",  32'(t_cart_d),     32'hFF);
    tick(1);
    chk("tmo_valid_pulse", 32'(t_cart_valid), 32'd0);
    chk("tmo_sticky",      32'(t_tmo_err),    32'd1);
    ioctl_download = 1'b1;
    tick(1);
    ioctl_download = 1'b0;
    chk("tmo_dl_clear", 32'(t_tmo_err), 32'd0);

    // u_dut is still waiting on 0x1234; fill its write buffer, then reset
    chk("pre_rst_data", 32'(cart_d), 32'h42);
    ioctl_wr = 1'b1; ioctl_addr = 25'h00FC000; ioctl_dout = 8'hAB;
    tick(1);
    ioctl_wr = 1'b0;
    chk("pre_rst_wait", 32'(ioctl_wait), 32'd1);
    reset = 1'b1;
    #2;
    chk("arst_wait",  32'(ioctl_wait), 32'd0);
    chk("arst_cart_d", 32'(cart_d),    32'hFF);
    tick(1);
    reset = 1'b0;
    mem_dout = 8'h99; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    chk("stale_valid", 32'(cart_valid), 32'd0);
    chk("stale_data",  32'(cart_d),     32'hFF);
    chk("stale_req",   32'(mem_req),    32'd0);
    tick(1);
    chk("post_rst_valid", 32'(cart_valid), 32'd0);
    chk("post_rst_req",   32'(mem_req),    32'd0);
    chk("post_rst_we",    32'(mem_we),     32'd0);
    chk("post_rst_addr",  32'(mem_addr),   32'd0);
    chk("post_rst_din",   32'(mem_din),    32'd0);
    chk("post_rst_wait",  32'(ioctl_wait), 32'd0);
    chk("post_rst_pages", 32'(cart_pages), 32'd0);
    chk("post_rst_tmo",   32'(tmo_err),    32'd0);
    chk("post_rst_ovf",   32'(ovf_err),    32'd0);

    // two reads of the same address
    req_cnt = 0; val_cnt = 0; d1 = '0; d2 = '0;
    mem_dout = 8'hE7; cart_a = 20'h00100; cart_rd = 1'b1;
    run_acked(4);
    cart_rd = 1'b1;
    run_acked(4);
`ifdef CART_READ_CACHE_EN
    chk("rep_rd_reqs", 32'(req_cnt), 32'd1);
`else
    chk("rep_rd_reqs", 32'(req_cnt), 32'd2);
`endif
    chk("rep_rd_valids", 32'(val_cnt), 32'd2);
    chk("rep_rd_d1",     32'(d1),      32'hE7);
    chk("rep_rd_d2",     32'(d2),      32'hE7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
